// File: rtl/mreq_rr_arbiter.sv
// ============================================================================
//  Module   : mreq_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one MREQ executor between NREQS
//             requesters; grant is held until the executor reports done.
//  Options  : MREQ_ARB_PRIO0_EN - requester 0 has absolute priority in IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mreq_rr_arbiter #(
    parameter int NREQS     = 2,
    parameter int IREQ_BITS = 1,
    parameter int MREQ_BITS = 44
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NREQS-1:0]           i_mreqs_valid,
    input  logic [NREQS*MREQ_BITS-1:0] i_mreqs,
    output logic [NREQS-1:0]           o_mreqs_ready,
    output logic                       o_mreq_valid,
    output logic [MREQ_BITS-1:0]       o_mreq,
    output logic [IREQ_BITS-1:0]       o_mreq_igrant,
    input  logic                       i_mreq_ready,
    input  logic                       i_mreq_done,
    output logic                       o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IREQ_BITS-1:0]   r_rr_ptr;

    logic                   w_found_hi;
    logic                   w_found_any;
    logic [IREQ_BITS-1:0]   w_sel_hi;
    logic [IREQ_BITS-1:0]   w_sel_lo;
    logic [IREQ_BITS-1:0]   w_sel;
    logic [MREQ_BITS-1:0]   w_sel_mreq;

    // Rotating scan without modulo: first valid at or above rr_ptr, otherwise
    // the lowest valid index overall (the wrapped part of the scan).
    always_comb begin
        w_found_hi  = 1'b0;
        w_found_any = 1'b0;
        w_sel_hi    = '0;
        w_sel_lo    = '0;
        for (int i = NREQS - 1; i >= 0; i--) begin
            if (i_mreqs_valid[i]) begin
                w_found_any = 1'b1;
                w_sel_lo    = IREQ_BITS'(i);
                if (IREQ_BITS'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_sel_hi   = IREQ_BITS'(i);
                end
            end
        end
        w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
`ifdef MREQ_ARB_PRIO0_EN
        if (i_mreqs_valid[0]) begin
            w_sel = '0;
        end
`endif
    end

    always_comb begin
        w_sel_mreq = '0;
        for (int i = 0; i < NREQS; i++) begin
            if (w_sel == IREQ_BITS'(i)) begin
                w_sel_mreq = i_mreqs[i*MREQ_BITS +: MREQ_BITS];
            end
        end
    end

    // Accept pulse decodes only in-range indices, so it can never go multi-hot.
    always_comb begin
        o_mreqs_ready = '0;
        if (r_state == ST_OFFER && i_mreq_ready) begin
            for (int i = 0; i < NREQS; i++) begin
                if (o_mreq_igrant == IREQ_BITS'(i)) begin
                    o_mreqs_ready[i] = 1'b1;
                end
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            o_mreq_valid  <= 1'b0;
            o_mreq        <= '0;
            o_mreq_igrant <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found_any) begin
                        o_mreq        <= w_sel_mreq;
                        o_mreq_igrant <= w_sel;
                        o_mreq_valid  <= 1'b1;
                        r_state       <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (i_mreq_ready) begin
                        o_mreq_valid <= 1'b0;
                        r_state      <= ST_BUSY;
`ifdef MREQ_ARB_PRIO0_EN
                        if (o_mreq_igrant != '0) begin
`else
                        begin
`endif
                            if (o_mreq_igrant == IREQ_BITS'(NREQS - 1)) begin
                                r_rr_ptr <= '0;
                            end else begin
                                r_rr_ptr <= o_mreq_igrant + IREQ_BITS'(1);
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (i_mreq_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    o_mreq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mreq_rr_arbiter.sv
// ============================================================================
//  Module   : tb_mreq_rr_arbiter
//  Purpose  : Self-checking bench for mreq_rr_arbiter (NREQS=3) against a
//             rule-level grant model; honours MREQ_ARB_PRIO0_EN if defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mreq_rr_arbiter;

    localparam int NREQS     = 3;
    localparam int IREQ_BITS = 2;
    localparam int MREQ_BITS = 44;

    logic                       i_clk = 1'b0;
    logic                       i_rst_n = 1'b0;
    logic [NREQS-1:0]           valid_v = '0;
    logic [NREQS*MREQ_BITS-1:0] mreqs = '0;
    logic [NREQS-1:0]           o_mreqs_ready;
    logic                       o_mreq_valid;
    logic [MREQ_BITS-1:0]       o_mreq;
    logic [IREQ_BITS-1:0]       o_mreq_igrant;
    logic                       i_mreq_ready = 1'b0;
    logic                       i_mreq_done = 1'b0;
    logic                       o_busy;

    logic [MREQ_BITS-1:0]       d [NREQS];
    int                         ptr = 0;
    int                         n_tests = 0;
    int                         n_fail = 0;

    mreq_rr_arbiter #(
        .NREQS     (NREQS),
        .IREQ_BITS (IREQ_BITS),
        .MREQ_BITS (MREQ_BITS)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_mreqs_valid (valid_v),
        .i_mreqs       (mreqs),
        .o_mreqs_ready (o_mreqs_ready),
        .o_mreq_valid  (o_mreq_valid),
        .o_mreq        (o_mreq),
        .o_mreq_igrant (o_mreq_igrant),
        .i_mreq_ready  (i_mreq_ready),
        .i_mreq_done   (i_mreq_done),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < NREQS; k++) mreqs[k*MREQ_BITS +: MREQ_BITS] = d[k];
    endtask

    // Reference grant rule: first valid requester walking ptr, ptr+1, ... mod NREQS.
    function automatic int pick(input logic [NREQS-1:0] v, input int p);
`ifdef MREQ_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NREQS; k++) begin
            if (v[(p + k) % NREQS]) return (p + k) % NREQS;
        end
        return -1;
    endfunction

    function automatic int next_ptr(input int g, input int p);
`ifdef MREQ_ARB_PRIO0_EN
        if (g == 0) return p;
`endif
        return (g + 1) % NREQS;
    endfunction

    // One complete request: IDLE -> OFFER (stall cycles) -> accept -> BUSY -> IDLE.
    task automatic txn(input int stall, input int dlat, input bit done_acc,
                       input bit keep, output int g);
        logic [63:0] dexp;
        g    = pick(valid_v, ptr);
        dexp = 64'(d[g]);
        tick();
        check("offer_valid", 64'(o_mreq_valid), 64'd1);
        check("offer_data", 64'(o_mreq), dexp);
        check("offer_igrant", 64'(o_mreq_igrant), 64'(g));
        check("offer_busy", 64'(o_busy), 64'd1);
        check("offer_noready", 64'(o_mreqs_ready), 64'd0);
        for (int s = 0; s < stall; s++) begin
            i_mreq_done = 1'($urandom_range(0, 1));
            tick();
            check("stall_valid", 64'(o_mreq_valid), 64'd1);
            check("stall_data", 64'(o_mreq), dexp);
            check("stall_igrant", 64'(o_mreq_igrant), 64'(g));
            check("stall_noready", 64'(o_mreqs_ready), 64'd0);
        end
        i_mreq_done  = done_acc;
        i_mreq_ready = 1'b1;
        #1;
        check("accept_pulse", 64'(o_mreqs_ready), 64'(1) << g);
        tick();
        i_mreq_ready = 1'b0;
        i_mreq_done  = 1'b0;
        ptr = next_ptr(g, ptr);
        if (!keep) valid_v[g] = 1'b0;
        check("busy_state", 64'(o_busy), 64'd1);
        check("busy_valid", 64'(o_mreq_valid), 64'd0);
        check("busy_noready", 64'(o_mreqs_ready), 64'd0);
        for (int w = 0; w < dlat; w++) begin
            tick();
            check("busy_wait", 64'(o_busy), 64'd1);
        end
        i_mreq_done = 1'b1;
        tick();
        i_mreq_done = 1'b0;
        check("done_idle", 64'(o_busy), 64'd0);
        check("done_novalid", 64'(o_mreq_valid), 64'd0);
    endtask

    initial begin
        int g;
        int first;
        for (int k = 0; k < NREQS; k++) d[k] = '0;
        pack();

        // Reset state
        repeat (2) tick();
        check("rst_valid", 64'(o_mreq_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_igrant", 64'(o_mreq_igrant), 64'd0);
        check("rst_mreq", 64'(o_mreq), 64'd0);
        i_rst_n = 1'b1;
        tick();
        check("idle_empty", 64'(o_busy), 64'd0);

        // Single request from requester 1
        d[1] = 44'hAA1_2331_1223;
        pack();
        valid_v = 3'b010;
        txn(0, 1, 1'b0, 1'b0, g);
        check("t2_grant", 64'(g), 64'd1);

        // Reset mid-OFFER, then first grant goes to requester 0
        for (int k = 0; k < NREQS; k++) d[k] = {12'($urandom), $urandom};
        pack();
        valid_v = 3'b111;
        tick();
        check("t1_offer", 64'(o_mreq_valid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check("t1_valid0", 64'(o_mreq_valid), 64'd0);
        check("t1_mreq0", 64'(o_mreq), 64'd0);
        check("t1_igrant0", 64'(o_mreq_igrant), 64'd0);
        check("t1_busy0", 64'(o_busy), 64'd0);
        check("t1_ready0", 64'(o_mreqs_ready), 64'd0);
        ptr = 0;
        tick();
        i_rst_n = 1'b1;
        txn(0, 0, 1'b0, 1'b1, g);
        check("t1_first", 64'(g), 64'd0);

        // Fairness with all requesters permanently valid
        first = ptr;
        for (int i = 0; i < 6; i++) begin
            txn(0, 3, 1'b0, 1'b1, g);
`ifdef MREQ_ARB_PRIO0_EN
            check("t3_order", 64'(g), 64'd0);
`else
            check("t3_order", 64'(g), 64'((first + i) % NREQS));
`endif
        end

        // Long executor stall, then done pulses in IDLE and in the accept cycle
        txn(20, 1, 1'b0, 1'b1, g);
        valid_v = '0;
        i_mreq_done = 1'b1;
        tick();
        i_mreq_done = 1'b0;
        check("t5_idle_done", 64'(o_busy), 64'd0);
        valid_v = 3'b100;
        txn(2, 0, 1'b1, 1'b0, g);
        check("t5_grant", 64'(g), 64'd2);

        // Requester 0 absent: remaining two alternate
        valid_v = 3'b110;
        for (int i = 0; i < 4; i++) begin
            int prev;
            prev = g;
            txn(0, 1, 1'b0, 1'b1, g);
            if (i > 0) check("t6_alternate", 64'(g), 64'(prev == 1 ? 2 : 1));
        end

        // Randomized traffic against the reference model
        for (int r = 0; r < 60; r++) begin
            for (int k = 0; k < NREQS; k++) d[k] = {12'($urandom), $urandom};
            pack();
            valid_v = 3'($urandom_range(1, 7));
            txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g);
            if ($urandom_range(0, 3) == 0) begin
                valid_v = '0;
                tick();
                check("rnd_idle", 64'(o_busy), 64'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
